// File: rtl/gray_counter.sv
// Parametrised up/down counter that presents its state as registered binary and Gray code.
// Binary, Gray and the terminal-count pulse all come from one next-state, so they never skew.
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = 32'd0,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_bin_i,
  output logic [WIDTH-1:0] binary_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] MaxVal   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MinVal   = '0;
  localparam logic [WIDTH-1:0] RstBin   = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RstGray  = RstBin ^ (RstBin >> 1);
  localparam bit               WrapOn   = (WRAP_MODE != 0);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             term_q, term_d;

  // Load beats count; at a terminal count the step either wraps or holds, and flags term.
  always_comb begin
    bin_d  = bin_q;
    term_d = 1'b0;
    if (load_i) begin
      bin_d = load_bin_i;
    end else if (en_i) begin
      if (up_dn_i) begin
        if (bin_q == MaxVal) begin
          term_d = 1'b1;
          bin_d  = WrapOn ? MinVal : bin_q;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == MinVal) begin
          term_d = 1'b1;
          bin_d  = WrapOn ? MaxVal : bin_q;
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= RstBin;
      gray_q <= RstGray;
      term_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      term_q <= term_d;
    end
  end

  assign binary_o = bin_q;
  assign gray_o   = gray_q;
  assign term_o   = term_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three configurations (4-bit wrap, 4-bit saturate, 8-bit wrap)
// checked against an integer-arithmetic reference model.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [3];
  logic       en      [3];
  logic       up      [3];
  logic       load    [3];
  logic [7:0] loadBin [3];

  logic [3:0] bin0, gray0;
  logic [3:0] bin1, gray1;
  logic [7:0] bin2, gray2;
  logic       term0, term1, term2;

  int cfgWidth [3] = '{4, 4, 8};
  int cfgWrap  [3] = '{1, 0, 1};
  int cfgReset [3] = '{5, 0, 3};

  int mBin  [3];
  bit mTerm [3];

  int assertCount = 0;
  int failCount   = 0;

  gray_counter #(.WIDTH(4), .RESET_VAL(32'd5), .WRAP_MODE(1)) uWrap4 (
    .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .up_dn_i(up[0]), .load_i(load[0]),
    .load_bin_i(loadBin[0][3:0]), .binary_o(bin0), .gray_o(gray0), .term_o(term0));

  gray_counter #(.WIDTH(4), .RESET_VAL(32'd0), .WRAP_MODE(0)) uSat4 (
    .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .up_dn_i(up[1]), .load_i(load[1]),
    .load_bin_i(loadBin[1][3:0]), .binary_o(bin1), .gray_o(gray1), .term_o(term1));

  gray_counter #(.WIDTH(8), .RESET_VAL(32'd3), .WRAP_MODE(1)) uWrap8 (
    .clk_i(clk), .rst_i(rst[2]), .en_i(en[2]), .up_dn_i(up[2]), .load_i(load[2]),
    .load_bin_i(loadBin[2]), .binary_o(bin2), .gray_o(gray2), .term_o(term2));

  function automatic logic [31:0] dutBin(input int k);
    case (k)
      0:       return {28'd0, bin0};
      1:       return {28'd0, bin1};
      default: return {24'd0, bin2};
    endcase
  endfunction

  function automatic logic [31:0] dutGray(input int k);
    case (k)
      0:       return {28'd0, gray0};
      1:       return {28'd0, gray1};
      default: return {24'd0, gray2};
    endcase
  endfunction

  function automatic logic [31:0] dutTerm(input int k);
    case (k)
      0:       return {31'd0, term0};
      1:       return {31'd0, term1};
      default: return {31'd0, term2};
    endcase
  endfunction

  // Reference: plain integer step, then clamp or fold back into 0..2**W-1.
  task automatic modelStep(input int k);
    int span;
    int nxt;
    span = 1 << cfgWidth[k];
    if (rst[k]) begin
      mBin[k]  = cfgReset[k];
      mTerm[k] = 1'b0;
    end else if (load[k]) begin
      mBin[k]  = int'(loadBin[k]) % span;
      mTerm[k] = 1'b0;
    end else if (en[k]) begin
      nxt = up[k] ? mBin[k] + 1 : mBin[k] - 1;
      mTerm[k] = (nxt < 0) || (nxt >= span);
      if (!mTerm[k])         mBin[k] = nxt;
      else if (cfgWrap[k] != 0) mBin[k] = (nxt + span) % span;
    end else begin
      mTerm[k] = 1'b0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int k);
    logic [31:0] expBin;
    expBin = 32'(mBin[k]);
    checkVal({tag, "_bin"},  dutBin(k),  expBin);
    checkVal({tag, "_gray"}, dutGray(k), expBin ^ (expBin >> 1));
    checkVal({tag, "_term"}, dutTerm(k), {31'd0, mTerm[k]});
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < 3; k++) modelStep(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b1; load[k] = 1'b0; loadBin[k] = 8'd0;
    end
  endtask

  task automatic loadValue(input int k, input int v);
    load[k] = 1'b1; loadBin[k] = 8'(v);
    applyStimulus();
    load[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] prevGray;
    int expSeq[4];

    idleAll();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    load[0] = 1'b1; loadBin[0] = 8'd9; en[0] = 1'b1;
    applyStimulus();
    checkVal("rst_bin_const",  dutBin(0),  32'd5);
    checkVal("rst_gray_const", dutGray(0), 32'b0111);
    checkVal("rst_term_const", dutTerm(0), 32'd0);
    for (int k = 0; k < 3; k++) checkOutput("reset", k);

    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    applyStimulus();
    checkVal("load_over_en_bin",  dutBin(0),  32'd9);
    checkVal("load_over_en_gray", dutGray(0), 32'b1101);
    checkOutput("load_over_en", 0);

    // Full up sweep on the 4-bit wrapping instance.
    idleAll();
    loadValue(0, 0);
    en[0] = 1'b1; up[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prevGray = dutGray(0);
      applyStimulus();
      checkOutput("up_sweep", 0);
      checkVal("up_sweep_hamming", 32'($countones(prevGray ^ dutGray(0))), 32'd1);
      checkVal("up_sweep_term", dutTerm(0), (i == 15) ? 32'd1 : 32'd0);
    end
    checkVal("up_sweep_end_gray", dutGray(0), 32'd0);

    up[0] = 1'b0;
    applyStimulus();
    checkVal("down_wrap_bin",  dutBin(0),  32'd15);
    checkVal("down_wrap_gray", dutGray(0), 32'b1000);
    checkVal("down_wrap_term", dutTerm(0), 32'd1);
    applyStimulus();
    checkVal("down_after_bin",  dutBin(0),  32'd14);
    checkVal("down_after_gray", dutGray(0), 32'b1001);
    checkVal("down_after_term", dutTerm(0), 32'd0);

    // Direction toggle every cycle, then hold.
    en[0] = 1'b0;
    loadValue(0, 7);
    en[0] = 1'b1;
    expSeq = '{8, 7, 8, 7};
    for (int i = 0; i < 4; i++) begin
      up[0] = (i % 2 == 0);
      applyStimulus();
      checkVal("toggle_bin", dutBin(0), 32'(expSeq[i]));
      checkOutput("toggle", 0);
    end
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkVal("hold_bin",  dutBin(0),  32'd7);
      checkVal("hold_gray", dutGray(0), 32'b0100);
      checkVal("hold_term", dutTerm(0), 32'd0);
    end

    // Saturation at both ends on the 4-bit saturating instance.
    loadValue(1, 14);
    en[1] = 1'b1; up[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkVal("sat_hi_bin",  dutBin(1),  32'd15);
      checkVal("sat_hi_term", dutTerm(1), (i == 0) ? 32'd0 : 32'd1);
      checkOutput("sat_hi", 1);
    end
    up[1] = 1'b0;
    applyStimulus();
    checkVal("sat_hi_down_bin",  dutBin(1),  32'd14);
    checkVal("sat_hi_down_term", dutTerm(1), 32'd0);
    en[1] = 1'b0;
    loadValue(1, 1);
    en[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkVal("sat_lo_bin",  dutBin(1),  32'd0);
      checkVal("sat_lo_gray", dutGray(1), 32'd0);
      checkVal("sat_lo_term", dutTerm(1), (i == 0) ? 32'd0 : 32'd1);
    end

    // 8-bit: count to 200, then reset mid-count.
    idleAll();
    loadValue(2, 0);
    en[2] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus();
      checkOutput("count200", 2);
    end
    checkVal("count200_bin", dutBin(2), 32'd200);
    rst[2] = 1'b1;
    applyStimulus();
    checkVal("midreset_bin",  dutBin(2),  32'd3);
    checkVal("midreset_gray", dutGray(2), 32'd2);
    checkVal("midreset_term", dutTerm(2), 32'd0);
    rst[2] = 1'b0;

    // Random run across all three configurations.
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 3; k++) begin
        rst[k]     = ($urandom_range(63) == 0);
        load[k]    = ($urandom_range(15) == 0);
        en[k]      = ($urandom_range(3) != 0);
        up[k]      = $urandom_range(1) == 1;
        loadBin[k] = 8'($urandom);
      end
      applyStimulus();
      for (int k = 0; k < 3; k++) begin
        checkOutput("random", k);
        checkVal("random_gray_rel", dutGray(k), dutBin(k) ^ (dutBin(k) >> 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
